// File: rtl/mcp3202_spi_master.sv
// MCP3202 SPI master: sends the 4-bit command and captures the 12-bit MSB-first result.
// When LSB-first mode is selected, it also checks the trailing LSB-first copy against that result.
module mcp3202_spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_sgl_diff,
  input  logic        i_odd_sign,
  input  logic        i_msbf,
  output logic        o_spi_clk,
  output logic        o_cs,
  output logic        o_din,
  input  logic        i_dout,
  output logic        o_busy,
  output logic        o_done,
  output logic [11:0] o_adc_data,
  output logic        o_lsb_err
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [4:0] PER_MSB_FIRST = 5'd6;
  localparam logic [4:0] PER_MSB_LAST  = 5'd17;
  localparam logic [4:0] PER_LSB_FIRST = 5'd18;
  localparam logic [4:0] PER_LSB_LAST  = 5'd28;
  localparam logic [4:0] PER_END_MSBF  = 5'd18;
  localparam logic [4:0] PER_END_LSBF  = 5'd29;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_TRAIL,
    S_GAP
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_div;
  logic [4:0]      r_per;
  logic            r_spi_clk;
  logic            r_cs;
  logic            r_din;
  logic            r_busy;
  logic            r_done;
  logic            r_sgl_diff;
  logic            r_odd_sign;
  logic            r_msbf;
  logic [11:0]     r_msb_sr;
  logic [10:0]     r_lsb_sr;
  logic [11:0]     r_adc_data;
  logic            r_lsb_err;

  state_t          w_state_nxt;
  logic [DW-1:0]   w_div_nxt;
  logic [4:0]      w_per_nxt;
  logic            w_spi_clk_nxt;
  logic            w_cs_nxt;
  logic            w_din_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;
  logic            w_cmd_ld;
  logic            w_cap_msb;
  logic            w_cap_lsb;
  logic            w_commit;
  logic            w_div_last;
  logic [4:0]      w_per_inc;
  logic [4:0]      w_per_end;
  logic            w_din_sched;

  assign w_div_last = (r_div == DIV_LAST);
  assign w_per_inc  = r_per + 5'd1;
  assign w_per_end  = r_msbf ? PER_END_MSBF : PER_END_LSBF;

  // Command bit presented with the rising edge of the period about to start.
  always_comb begin
    w_din_sched = 1'b0;
    case (w_per_inc)
      5'd2:    w_din_sched = r_sgl_diff;
      5'd3:    w_din_sched = r_odd_sign;
      5'd4:    w_din_sched = r_msbf;
      default: w_din_sched = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_div_nxt     = r_div;
    w_per_nxt     = r_per;
    w_spi_clk_nxt = r_spi_clk;
    w_cs_nxt      = r_cs;
    w_din_nxt     = r_din;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_cmd_ld      = 1'b0;
    w_cap_msb     = 1'b0;
    w_cap_lsb     = 1'b0;
    w_commit      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_LEAD;
          w_cs_nxt    = 1'b0;
          w_din_nxt   = 1'b1;
          w_busy_nxt  = 1'b1;
          w_div_nxt   = '0;
          w_per_nxt   = '0;
          w_cmd_ld    = 1'b1;
        end
      end

      S_LEAD: begin
        if (w_div_last) begin
          w_state_nxt   = S_SHIFT;
          w_div_nxt     = '0;
          w_per_nxt     = 5'd1;
          w_spi_clk_nxt = 1'b1;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end

      S_SHIFT: begin
        // dout is sampled in the first high cycle of each period.
        if (r_spi_clk && (r_div == '0)) begin
          w_cap_msb = (r_per >= PER_MSB_FIRST) && (r_per <= PER_MSB_LAST);
          w_cap_lsb = !r_msbf && (r_per >= PER_LSB_FIRST) && (r_per <= PER_LSB_LAST);
        end
        if (w_div_last) begin
          w_div_nxt = '0;
          if (r_spi_clk) begin
            w_spi_clk_nxt = 1'b0;
          end else if (r_per == w_per_end) begin
            w_state_nxt = S_TRAIL;
          end else begin
            w_per_nxt     = w_per_inc;
            w_spi_clk_nxt = 1'b1;
            w_din_nxt     = w_din_sched;
          end
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end

      S_TRAIL: begin
        if (w_div_last) begin
          w_state_nxt = S_GAP;
          w_div_nxt   = '0;
          w_cs_nxt    = 1'b1;
          w_din_nxt   = 1'b0;
          w_done_nxt  = 1'b1;
          w_commit    = 1'b1;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end

      S_GAP: begin
        if (w_div_last) begin
          w_state_nxt = S_IDLE;
          w_div_nxt   = '0;
          w_busy_nxt  = 1'b0;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_per      <= '0;
      r_spi_clk  <= 1'b0;
      r_cs       <= 1'b1;
      r_din      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sgl_diff <= 1'b0;
      r_odd_sign <= 1'b0;
      r_msbf     <= 1'b0;
      r_msb_sr   <= '0;
      r_lsb_sr   <= '0;
      r_adc_data <= '0;
      r_lsb_err  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= w_div_nxt;
      r_per     <= w_per_nxt;
      r_spi_clk <= w_spi_clk_nxt;
      r_cs      <= w_cs_nxt;
      r_din     <= w_din_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      if (w_cmd_ld) begin
        r_sgl_diff <= i_sgl_diff;
        r_odd_sign <= i_odd_sign;
        r_msbf     <= i_msbf;
      end
      if (w_cap_msb) begin
        r_msb_sr <= {r_msb_sr[10:0], i_dout};
      end
      // LSB-first copy arrives B1..B11; shifting right leaves B11..B1 aligned to msb_sr[11:1].
      if (w_cap_lsb) begin
        r_lsb_sr <= {i_dout, r_lsb_sr[10:1]};
      end
      if (w_commit) begin
        r_adc_data <= r_msb_sr;
        r_lsb_err  <= !r_msbf && (r_lsb_sr != r_msb_sr[11:1]);
      end
    end
  end

  assign o_spi_clk  = r_spi_clk;
  assign o_cs       = r_cs;
  assign o_din      = r_din;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_adc_data = r_adc_data;
  assign o_lsb_err  = r_lsb_err;

endmodule
